// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
//   Memory-stage load/store sequencer between the vector pipeline and a
//   32-bit data memory. A scalar access becomes one word transaction. A
//   vector access becomes L sequential word transactions, one per lane.
//   Lanes whose byte address exceeds ADDR_MAX are skipped and flagged.
//
// Ports
//   clk, rst     : clock; asynchronous active-low reset
//   req_*        : memory-stage request (valid, we, vec, addr, wdata)
//   stall        : pipeline memory stall, combinational
//   rdata        : assembled load data, held until the next load starts
//   rdata_valid  : one-cycle pulse in DONE for loads
//   err          : one-cycle pulse in DONE when a lane was suppressed
//   mem_*        : single-word memory port (req/we/addr/wdata out, rdata/ack in)

module vec_mem_sequencer #(
    parameter int unsigned  N        = 32,
    parameter int unsigned  V        = 128,
    parameter logic [N-1:0] ADDR_MAX = N'(32'h4AFFF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic         req_vec,
    input  logic [N-1:0] req_addr,
    input  logic [V-1:0] req_wdata,
    output logic         stall,
    output logic [V-1:0] rdata,
    output logic         rdata_valid,
    output logic         err,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata,
    input  logic         mem_ack
);

    localparam int unsigned L  = V / N;
    localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic [LW-1:0]  lane_q;
    logic           err_q;
    logic           we_q;
    logic           vec_q;
    logic [N-1:0]   addr_q;
    logic [V-1:0]   wdata_q;
    logic [V-1:0]   rdata_q;

    logic [N-1:0]   lane_addr;
    logic           lane_ok;
    logic           lane_last;
    logic [N-1:0]   lane_wdata;
    logic           issuing;

    // Current lane decode: address wraps modulo 2^N before the limit compare.
    always_comb begin
        lane_addr  = addr_q + (N'(lane_q) << 2);
        lane_ok    = (lane_addr <= ADDR_MAX);
        lane_last  = vec_q ? (lane_q == LW'(L - 1)) : (lane_q == '0);
        lane_wdata = '0;
        for (int i = 0; i < int'(L); i++) begin
            if (lane_q == LW'(i)) begin
                lane_wdata = wdata_q[i*N +: N];
            end
        end
        issuing    = (state_q == ISSUE) && lane_ok;
    end

    // Sequencer state, captured request and read assembly buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            vec_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        vec_q   <= req_vec;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= 1'b0;
                        lane_q  <= '0;
                        // Stores leave the previous load result visible.
                        if (!req_we) begin
                            rdata_q <= '0;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A suppressed lane advances without waiting for memory.
                    if (!lane_ok || mem_ack) begin
                        if (lane_ok && !we_q) begin
                            for (int i = 0; i < int'(L); i++) begin
                                if (lane_q == LW'(i)) begin
                                    rdata_q[i*N +: N] <= mem_rdata;
                                end
                            end
                        end
                        if (!lane_ok) begin
                            err_q <= 1'b1;
                        end
                        if (lane_last) begin
                            state_q <= DONE;
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state; stall also sees the incoming request.
    always_comb begin
        stall       = rst && (((state_q == IDLE) && req_valid) || (state_q == ISSUE));
        rdata       = rdata_q;
        rdata_valid = (state_q == DONE) && !we_q;
        err         = (state_q == DONE) && err_q;
        mem_req     = issuing;
        mem_we      = issuing && we_q;
        mem_addr    = issuing ? lane_addr  : '0;
        mem_wdata   = issuing ? lane_wdata : '0;
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed self-checking bench for vec_mem_sequencer with a cycle-stepped
// memory responder embedded in run_access.

module tb_vec_mem_sequencer;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_we;
    logic         req_vec;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         stall;
    logic [127:0] rdata;
    logic         rdata_valid;
    logic         err;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    vec_mem_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_vec     (req_vec),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent run_access.
    logic [31:0]  rd_words [4];
    logic [31:0]  txn_addr [$];
    logic [31:0]  txn_wdata[$];
    logic         txn_we   [$];
    int           stall_cnt;
    int           stable_err;
    int           rv_cnt;
    logic         first_stall;
    logic         rv_at_done;
    logic         err_at_done;
    logic [127:0] rdata_at_done;
    logic         timed_out;

    // Issues one access in the current cycle (posedge+1) and services memory
    // until the first stall-free cycle (DONE). Returns inside the DONE cycle.
    task automatic run_access(input logic we, input logic vec, input logic [31:0] addr,
                              input logic [127:0] wdata, input int waits,
                              input logic ack_idle, input logic ack_done);
        int cyc;
        int wcnt;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic        h_we;
        txn_addr.delete();
        txn_wdata.delete();
        txn_we.delete();
        stall_cnt  = 0;
        stable_err = 0;
        rv_cnt     = 0;
        timed_out  = 1'b0;
        h_addr     = '0;
        h_wdata    = '0;
        h_we       = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_vec    = vec;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_ack    = ack_idle;
        mem_rdata  = 32'hDEAD0000;
        wcnt = 0;
        cyc  = 0;
        #1;
        first_stall = stall;
        forever begin
            if (stall) stall_cnt++;
            if (rdata_valid) rv_cnt++;
            if (cyc > 0 && !stall) begin
                rv_at_done    = rdata_valid;
                err_at_done   = err;
                rdata_at_done = rdata;
                mem_ack       = ack_done;
                mem_rdata     = 32'hBAD0BAD0;
                break;
            end
            if (cyc > 0 && mem_req) begin
                if (wcnt == 0) begin
                    h_addr  = mem_addr;
                    h_wdata = mem_wdata;
                    h_we    = mem_we;
                end else if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_we !== h_we) begin
                    stable_err++;
                end
                if (wcnt == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_words[txn_addr.size() % 4];
                    txn_addr.push_back(mem_addr);
                    txn_wdata.push_back(mem_wdata);
                    txn_we.push_back(mem_we);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else if (cyc > 0) begin
                mem_ack = 1'b0;
            end
            cyc++;
            if (cyc > 200) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            mem_ack   = 1'b0;
            #1;
        end
    endtask

    task automatic step_idle();
        @(posedge clk);
        #1;
        mem_ack   = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_ctrl: stall=%b mem_req=%b mem_we=%b want 0", stall, mem_req, mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata); else n_pass++;
        n_checks++; if (rdata !== 128'h0 || rdata_valid !== 1'b0 || err !== 1'b0) $display("FAIL reset_rd: rdata=%h rv=%b err=%b want 0", rdata, rdata_valid, err); else n_pass++;
        @(posedge clk); #1; rst = 1'b1;
        step_idle();
        n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0) $display("FAIL reset_idle: stall=%b mem_req=%b want 0", stall, mem_req); else n_pass++;
    endtask

    task automatic test_vector_load();
        rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
        run_access(1'b0, 1'b1, 32'h100, '0, 0, 1'b0, 1'b0);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL vload_timeout: got %b want 0", timed_out); else n_pass++;
        n_checks++; if (txn_addr.size() !== 4) $display("FAIL vload_ntxn: got %0d want 4", txn_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (txn_addr[i] !== 32'h100 + 32'(4*i) || txn_we[i] !== 1'b0) $display("FAIL vload_addr%0d: got %h we=%b want %h we=0", i, txn_addr[i], txn_we[i], 32'h100 + 32'(4*i)); else n_pass++;
        end
        n_checks++; if (stall_cnt !== 5) $display("FAIL vload_stall: got %0d want 5", stall_cnt); else n_pass++;
        n_checks++; if (rdata_at_done !== 128'h00000044_00000033_00000022_00000011) $display("FAIL vload_rdata: got %h want %h", rdata_at_done, 128'h00000044_00000033_00000022_00000011); else n_pass++;
        n_checks++; if (rv_at_done !== 1'b1 || rv_cnt !== 1 || err_at_done !== 1'b0) $display("FAIL vload_pulse: rv=%b cnt=%0d err=%b want 1/1/0", rv_at_done, rv_cnt, err_at_done); else n_pass++;
        step_idle();
        n_checks++; if (rdata_valid !== 1'b0 || rdata !== 128'h00000044_00000033_00000022_00000011) $display("FAIL vload_hold: rv=%b rdata=%h want 0 and held", rdata_valid, rdata); else n_pass++;
    endtask

    task automatic test_vector_store();
        logic [31:0] exp_w;
        run_access(1'b1, 1'b1, 32'h200, 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 2, 1'b0, 1'b0);
        n_checks++; if (timed_out !== 1'b0) $display("FAIL vstore_timeout: got %b want 0", timed_out); else n_pass++;
        n_checks++; if (txn_addr.size() !== 4) $display("FAIL vstore_ntxn: got %0d want 4", txn_addr.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            exp_w = 32'h0000AAAA + 32'(i * 32'h1111);
            n_checks++; if (txn_addr[i] !== 32'h200 + 32'(4*i) || txn_wdata[i] !== exp_w || txn_we[i] !== 1'b1) $display("FAIL vstore_txn%0d: got %h/%h/%b want %h/%h/1", i, txn_addr[i], txn_wdata[i], txn_we[i], 32'h200 + 32'(4*i), exp_w); else n_pass++;
        end
        n_checks++; if (stable_err !== 0) $display("FAIL vstore_stable: got %0d changes want 0", stable_err); else n_pass++;
        n_checks++; if (stall_cnt !== 13) $display("FAIL vstore_stall: got %0d want 13", stall_cnt); else n_pass++;
        n_checks++; if (rv_cnt !== 0 || err_at_done !== 1'b0) $display("FAIL vstore_pulse: rv_cnt=%0d err=%b want 0/0", rv_cnt, err_at_done); else n_pass++;
        step_idle();
    endtask

    task automatic test_scalar_load();
        rd_words[0] = 32'hCAFEBABE;
        run_access(1'b0, 1'b0, 32'h4AFFC, '0, 0, 1'b0, 1'b0);
        n_checks++; if (txn_addr.size() !== 1 || txn_addr[0] !== 32'h4AFFC) $display("FAIL sload_txn: n=%0d addr=%h want 1/0004affc", txn_addr.size(), txn_addr[0]); else n_pass++;
        n_checks++; if (stall_cnt !== 2) $display("FAIL sload_stall: got %0d want 2", stall_cnt); else n_pass++;
        n_checks++; if (rdata_at_done !== 128'h0_CAFEBABE || rv_at_done !== 1'b1 || err_at_done !== 1'b0) $display("FAIL sload_rdata: got %h rv=%b err=%b want %h rv=1 err=0", rdata_at_done, rv_at_done, err_at_done, 128'h0_CAFEBABE); else n_pass++;
        step_idle();
    endtask

    task automatic test_scalar_store();
        run_access(1'b1, 1'b1 ^ 1'b1, 32'h80, 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_12345678, 1, 1'b0, 1'b0);
        n_checks++; if (txn_addr.size() !== 1 || txn_wdata[0] !== 32'h12345678 || txn_we[0] !== 1'b1) $display("FAIL sstore_txn: n=%0d wdata=%h want 1/12345678", txn_addr.size(), txn_wdata[0]); else n_pass++;
        n_checks++; if (stall_cnt !== 3 || rv_cnt !== 0) $display("FAIL sstore_stall: stall=%0d rv=%0d want 3/0", stall_cnt, rv_cnt); else n_pass++;
        step_idle();
    endtask

    task automatic test_boundary();
        rd_words[0] = 32'h55; rd_words[1] = 32'h66;
        run_access(1'b0, 1'b1, 32'h4AFF8, '0, 0, 1'b0, 1'b0);
        n_checks++; if (txn_addr.size() !== 2 || txn_addr[0] !== 32'h4AFF8 || txn_addr[1] !== 32'h4AFFC) $display("FAIL bound_txn: n=%0d a0=%h a1=%h want 2/0004aff8/0004affc", txn_addr.size(), txn_addr[0], txn_addr[1]); else n_pass++;
        n_checks++; if (stall_cnt !== 5) $display("FAIL bound_stall: got %0d want 5", stall_cnt); else n_pass++;
        n_checks++; if (rdata_at_done !== 128'h00000000_00000000_00000066_00000055) $display("FAIL bound_rdata: got %h want %h", rdata_at_done, 128'h00000000_00000000_00000066_00000055); else n_pass++;
        n_checks++; if (err_at_done !== 1'b1 || rv_at_done !== 1'b1) $display("FAIL bound_err: err=%b rv=%b want 1/1", err_at_done, rv_at_done); else n_pass++;
        step_idle();
        n_checks++; if (err !== 1'b0) $display("FAIL bound_err_pulse: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_wrap();
        rd_words[0] = 32'hA1; rd_words[1] = 32'hA2;
        run_access(1'b0, 1'b1, 32'hFFFFFFF8, '0, 0, 1'b0, 1'b0);
        n_checks++; if (txn_addr.size() !== 2 || txn_addr[0] !== 32'h0 || txn_addr[1] !== 32'h4) $display("FAIL wrap_txn: n=%0d a0=%h a1=%h want 2/0/4", txn_addr.size(), txn_addr[0], txn_addr[1]); else n_pass++;
        n_checks++; if (rdata_at_done !== 128'h000000A2_000000A1_00000000_00000000 || err_at_done !== 1'b1) $display("FAIL wrap_rdata: got %h err=%b want %h err=1", rdata_at_done, err_at_done, 128'h000000A2_000000A1_00000000_00000000); else n_pass++;
        step_idle();
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b1, 32'h300, 128'h4_00000003_00000002_00000001, 0, 1'b0, 1'b1);
        n_checks++; if (stall_cnt !== 5 || txn_addr.size() !== 4 || rv_at_done !== 1'b0) $display("FAIL b2b_store: stall=%0d n=%0d rv=%b want 5/4/0", stall_cnt, txn_addr.size(), rv_at_done); else n_pass++;
        @(posedge clk); #1;
        rd_words[0] = 32'h12345678;
        run_access(1'b0, 1'b0, 32'h40, '0, 0, 1'b1, 1'b0);
        n_checks++; if (first_stall !== 1'b1 || stall_cnt !== 2) $display("FAIL b2b_load_stall: first=%b cnt=%0d want 1/2", first_stall, stall_cnt); else n_pass++;
        n_checks++; if (txn_addr.size() !== 1 || txn_addr[0] !== 32'h40 || txn_we[0] !== 1'b0) $display("FAIL b2b_load_txn: n=%0d addr=%h want 1/00000040", txn_addr.size(), txn_addr[0]); else n_pass++;
        n_checks++; if (rdata_at_done !== 128'h0_12345678 || rv_at_done !== 1'b1) $display("FAIL b2b_load_rdata: got %h rv=%b want %h rv=1", rdata_at_done, rv_at_done, 128'h0_12345678); else n_pass++;
        step_idle();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_vec = 1'b1; req_addr = 32'h100; req_wdata = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11;
        @(posedge clk); #1;
        mem_rdata = 32'h22;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h108 || stall !== 1'b1) $display("FAIL rmid_lane2: req=%b addr=%h stall=%b want 1/00000108/1", mem_req, mem_addr, stall); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) $display("FAIL rmid_mem: stall=%b req=%b addr=%h want 0", stall, mem_req, mem_addr); else n_pass++;
        n_checks++; if (rdata !== 128'h0 || rdata_valid !== 1'b0 || err !== 1'b0) $display("FAIL rmid_rd: rdata=%h rv=%b err=%b want 0", rdata, rdata_valid, err); else n_pass++;
        @(posedge clk); #1; rst = 1'b1;
        step_idle();
        step_idle();
        n_checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== 128'h0 || rdata_valid !== 1'b0) $display("FAIL rmid_after: stall=%b req=%b rdata=%h rv=%b want 0", stall, mem_req, rdata, rdata_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vector_load();
        test_vector_store();
        test_scalar_load();
        test_scalar_store();
        test_boundary();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
